// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin sequencer time-sharing one combinational 32-bit multiplier among NREQ requesters.
// Define MULT_ARB_STATS_EN to add per-requester completed-job counters (stat_clr/stat_cnt).
module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_x,
  input  logic [NREQ-1:0]   req_s,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_y,
  output logic [IDW-1:0]    resp_id,
  output logic [31:0]       mul_x,
  output logic              mul_s,
  input  logic [31:0]       mul_y,
`ifdef MULT_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [NREQ*16-1:0] stat_cnt,
`endif
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t state;
  logic [IDW-1:0] ptr, id, gnt;
  logic gnt_ok;
  logic [3:0] cnt;
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
    return IDW'((int'(p) + k) % NREQ);
  endfunction
  // Scan from farthest to nearest so the requester closest after ptr is the one left standing.
  always_comb begin
    gnt = '0;
    gnt_ok = 1'b0;
    for (int k = NREQ; k >= 1; k--)
      if (req_valid[rr_idx(ptr, k)]) begin
        gnt = rr_idx(ptr, k);
        gnt_ok = 1'b1;
      end
  end
  assign req_ready = (state == IDLE && gnt_ok && !rst) ? NREQ'(1) << gnt : '0;
  assign resp_valid = state == RESP;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= IDW'(NREQ - 1);
      id <= '0;
      cnt <= '0;
      mul_x <= '0;
      mul_s <= 1'b0;
      resp_y <= '0;
      resp_id <= '0;
    end else
      case (state)
        IDLE: if (gnt_ok) begin
          mul_x <= req_x[32*gnt +: 32];
          mul_s <= req_s[gnt];
          id <= gnt;
          ptr <= gnt;
          cnt <= 4'(SETTLE_CYC - 1);
          state <= SETTLE;
        end
        SETTLE: if (cnt == 4'd0) begin
          resp_y <= mul_y;
          resp_id <= id;
          state <= RESP;
        end else cnt <= cnt - 4'd1;
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef MULT_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [15:0] c;
    always_ff @(posedge clk or posedge rst)
      if (rst) c <= '0;
      else if (stat_clr) c <= '0;
      else if (resp_valid && resp_ready && resp_id == IDW'(i) && c != 16'hFFFF) c <= c + 16'd1;
    assign stat_cnt[16*i +: 16] = c;
  end
`endif
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: directed bench with a job-level reference model checked every cycle.
module tb_mult_share_arb;
  localparam int N = 4;
  localparam int W = 2;
  localparam int SC = 1;
  logic clk = 0, rst = 1, rst4 = 1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_s = '0, req_ready;
  logic [N*32-1:0] req_x = '0;
  logic resp_valid, resp_ready = 0, mul_s, busy;
  logic [31:0] resp_y, mul_x, mul_y;
  logic [W-1:0] resp_id;
  logic [N-1:0] v4 = '0, s4 = '0, ready4;
  logic [N*32-1:0] x4 = '0;
  logic rv4, rr4 = 1, ms4, busy4;
  logic [31:0] y4, mx4, my4;
  logic [W-1:0] id4;
  int checks = 0, fails = 0;
`ifdef MULT_ARB_STATS_EN
  logic stat_clr = 0;
  logic [N*16-1:0] stat_cnt, stat_cnt4;
`endif
  function automatic logic [31:0] mf(input logic [31:0] x, input logic s);
    return s ? x * 32'd3 : x * 32'd5;
  endfunction
  assign mul_y = mf(mul_x, mul_s);
  assign my4 = mf(mx4, ms4);
  mult_share_arb #(.NREQ(N), .IDW(W), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_s(req_s),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y), .resp_id(resp_id),
    .mul_x(mul_x), .mul_s(mul_s), .mul_y(mul_y),
`ifdef MULT_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_cnt(stat_cnt),
`endif
    .busy(busy));
  mult_share_arb #(.NREQ(N), .IDW(W), .SETTLE_CYC(4)) dut4 (
    .clk(clk), .rst(rst4), .req_valid(v4), .req_ready(ready4), .req_x(x4), .req_s(s4),
    .resp_valid(rv4), .resp_ready(rr4), .resp_y(y4), .resp_id(id4),
    .mul_x(mx4), .mul_s(ms4), .mul_y(my4),
`ifdef MULT_ARB_STATS_EN
    .stat_clr(1'b0), .stat_cnt(stat_cnt4),
`endif
    .busy(busy4));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Job-level model: pending job, cycles since accept, RR pointer, held response.
  int m_ptr = N - 1, m_jid = 0, m_id = 0, m_t = 0;
  bit m_busy = 0, m_rv = 0;
  logic [31:0] m_x = '0, m_y = '0;
  logic m_s = 0;
  int m_cnt[N];
  function automatic int pick();
    for (int k = 1; k <= N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (rst) begin
      m_busy = 0; m_rv = 0; m_t = 0; m_ptr = N - 1; m_jid = 0; m_id = 0;
      m_x = '0; m_y = '0; m_s = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end
    g = pick();
    er = '0;
    if (!m_busy && !rst && g >= 0) er[g] = 1'b1;
    chk("m_req_ready", req_ready, er);
    chk("m_onehot", $onehot0(req_ready), 1);
    chk("m_busy", busy, m_busy);
    chk("m_resp_valid", resp_valid, m_rv);
    chk("m_resp_y", resp_y, m_y);
    chk("m_resp_id", resp_id, m_id);
    chk("m_mul_x", mul_x, m_x);
    chk("m_mul_s", mul_s, m_s);
`ifdef MULT_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("m_stat", stat_cnt[16*i +: 16], m_cnt[i]);
`endif
    if (!rst) begin
`ifdef MULT_ARB_STATS_EN
      if (stat_clr) foreach (m_cnt[i]) m_cnt[i] = 0;
      else if (m_rv && resp_ready && m_cnt[m_id] < 65535) m_cnt[m_id]++;
`endif
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1; m_t = 0; m_x = req_x[32*g +: 32]; m_s = req_s[g]; m_jid = g; m_ptr = g;
        end
      end else if (!m_rv) begin
        m_t++;
        if (m_t == SC) begin m_rv = 1; m_y = mf(m_x, m_s); m_id = m_jid; end
      end else if (resp_ready) begin
        m_rv = 0; m_busy = 0;
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_resp(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 40);
    chk("resp_seen", resp_valid, 1);
  endtask
  task automatic run(input int r, input logic [31:0] x, input logic s, input logic [31:0] ey, input int eid);
    int n;
    bit ok = 0;
    req_x[32*r +: 32] = x;
    req_s[r] = s;
    req_valid[r] = 1'b1;
    for (int k = 0; k < 30 && !ok; k++) begin @(negedge clk); ok = req_ready[r]; end
    chk("grant", ok, 1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    wait_resp(n);
    chk("latency", n, SC + 1);
    chk("job_y", resp_y, ey);
    chk("job_id", resp_id, eid);
  endtask
  initial begin
    int n;
    bit seen;
    cyc(2);
    chk("rst_ready", req_ready, 0);
    chk("rst_mul_x", mul_x, 0);
    chk("rst_valid", resp_valid, 0);
    rst = 0;
    rst4 = 0;
    resp_ready = 1;
    run(0, 1, 1, 3, 0); cyc(1);
    run(0, 1, 0, 5, 0); cyc(1);
    run(1, 32'h55375, 1, 1047135, 1); cyc(1);
    run(1, 32'h60000000, 0, 32'hE0000000, 1); cyc(1);
    rst = 1; cyc(1); rst = 0;
    chk("rst_busy", busy, 0);
    for (int i = 0; i < N; i++) begin req_x[32*i +: 32] = i + 1; req_s[i] = 1'b1; end
    req_valid = '1;
    for (int j = 0; j < 5; j++) begin
      wait_resp(n);
      chk("rr_id", resp_id, j % N);
      chk("rr_y", resp_y, 3 * (j % N + 1));
      cyc(1);
    end
    req_valid = '0;
    req_s = '0;
    resp_ready = 0;
    run(0, 3, 0, 15, 0);
    req_x[63:32] = 7;
    req_valid[1] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_y", resp_y, 15);
      chk("bp_id", resp_id, 0);
      chk("bp_ready", req_ready, 0);
      chk("bp_mul_x", mul_x, 3);
    end
    @(posedge clk); #1;
    resp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(n);
    chk("bp_next_y", resp_y, 35);
    chk("bp_next_id", resp_id, 1);
    cyc(1);
    x4[31:0] = 9;
    v4[0] = 1'b1;
    @(negedge clk);
    chk("d4_grant0", ready4, 4'b0001);
    @(posedge clk); #1;
    v4 = '0;
    cyc(1);
    chk("d4_busy_settle", busy4, 1);
    rst4 = 1;
    #1;
    chk("d4_busy_rst", busy4, 0);
    chk("d4_valid_rst", rv4, 0);
    chk("d4_mul_x_rst", mx4, 0);
    cyc(1);
    rst4 = 0;
    seen = 0;
    repeat (10) begin @(negedge clk); seen |= rv4; end
    chk("d4_no_resp", seen, 0);
    @(posedge clk); #1;
    x4[95:64] = 3;
    s4[2] = 1'b1;
    v4[2] = 1'b1;
    @(negedge clk);
    chk("d4_grant2", ready4, 4'b0100);
    @(posedge clk); #1;
    v4 = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rv4 && n < 40);
    chk("d4_latency", n, 5);
    chk("d4_y", y4, 9);
    chk("d4_id", id4, 2);
    cyc(1);
`ifdef MULT_ARB_STATS_EN
    rst = 1; cyc(1); rst = 0;
    chk("st_rst", stat_cnt, 0);
    run(0, 1, 1, 3, 0); cyc(1);
    run(3, 2, 0, 10, 3); cyc(1);
    run(0, 4, 0, 20, 0); cyc(1);
    run(0, 5, 1, 15, 0); cyc(1);
    @(negedge clk);
    chk("st_req0", stat_cnt[15:0], 3);
    chk("st_req3", stat_cnt[63:48], 1);
    @(posedge clk); #1;
    resp_ready = 0;
    run(0, 2, 1, 6, 0);
    @(posedge clk); #1;
    stat_clr = 1;
    resp_ready = 1;
    @(posedge clk); #1;
    stat_clr = 0;
    @(negedge clk);
    chk("st_clr_req0", stat_cnt[15:0], 0);
    chk("st_clr_req3", stat_cnt[63:48], 0);
`endif
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that time-shares one combinational reconfigurable 32-bit multiplier among NREQ requesters.
- Multiplier interface: data in x, mode select s, data out y.
- Accepts one job at a time over a valid/ready handshake and drives registered operands into the multiplier.
- Waits a programmable settle time, captures y, and returns the result with the requester ID over a valid/ready response channel.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, response ID width; must be ≥ clog2(NREQ).
- SETTLE_CYC, 1, cycles operands are held before y is captured (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  per-requester job request.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_x  in  NREQ*32  operands; requester i occupies bits [32i+31:32i].
- req_s  in  NREQ  mode select per requester.
- resp_valid  out  1  result available.
- resp_ready  in  1  result consumer accept.
- resp_y  out  32  captured multiplier result.
- resp_id  out  IDW  index of the requester that owns resp_y.
- mul_x  out  32  registered operand to the multiplier.
- mul_s  out  1  registered mode to the multiplier.
- mul_y  in  32  multiplier result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1), all outputs and registers cleared:
  - state=IDLE, req_ready=0, resp_valid=0, resp_y=0, resp_id=0, mul_x=0, mul_s=0, busy=0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
- Grant, computed combinationally in IDLE only:
  - Scan from ptr+1 upward, modulo NREQ; the first requester with req_valid high wins.
  - req_ready[g]=1 only for the winner while in IDLE; all other req_ready bits stay 0.
- Accept = req_valid[g] & req_ready[g] on a rising edge. On accept:
  - mul_x <= req_x[g], mul_s <= req_s[g], id <= g, ptr <= g.
  - settle counter <= SETTLE_CYC-1; state -> SETTLE.
- SETTLE:
  - mul_x and mul_s are held stable; counter decrements each cycle.
  - When the counter is 0: resp_y <= mul_y, resp_id <= id, state -> RESP.
- RESP:
  - resp_valid=1; resp_y and resp_id are held until resp_valid & resp_ready.
  - On that handshake: resp_valid deasserts on the next cycle; state -> IDLE.
  - resp_ready high on the first RESP cycle completes in that cycle.
- Latency:
  - Accept edge at cycle 0; resp_valid rises after cycle SETTLE_CYC+1.
  - With SETTLE_CYC=1, resp_valid is high in cycle 2.
  - Minimum issue interval is SETTLE_CYC+2 cycles, because IDLE lasts one cycle.
- Fairness: once granted, a requester has lowest priority at the next grant. With all NREQ requesters continuously valid, each is served once per NREQ jobs.
- A requester dropping req_valid before accept is legal; no job is issued for it.
- A requester asserting req_valid outside IDLE is ignored until IDLE.
- mul_x and mul_s keep the last job's values after completion, so no multiplier toggling occurs while idle.
- Overflow: none detected. resp_y is the multiplier's 32-bit output unmodified; truncation is the multiplier's behaviour.
- rst asserted mid-job (SETTLE or RESP): the job is discarded, no response is produced, and all reset values apply immediately.

Optional Feature:
- Macro: MULT_ARB_STATS_EN.
- Defined, the block adds these ports:
  - stat_clr  in  1  synchronous clear of all counters.
  - stat_cnt  out  NREQ*16  completed-job counters.
- Counter behaviour:
  - Counter i increments on each response handshake with resp_id=i.
  - Counters saturate at 0xFFFF.
  - stat_clr has priority over increment in the same cycle.
  - Reset value is 0.
- Undefined: the stat ports and counters are absent; all other behaviour is identical.

Test Plan:
- Bench multiplier model: mul_y = (mul_x * (mul_s ? 3 : 5)) mod 2^32.
- Reset/single job: rst pulse, then req0 x=1 s=1 with resp_ready=1 -> resp_valid in cycle 2 with resp_y=3, resp_id=0; then x=1 s=0 -> resp_y=5.
- Overflow pass-through: req1 x=349045 (0x55375) s=1 -> resp_y=1047135; x=0x60000000 s=0 -> resp_y=0xE0000000 (truncated).
- Round-robin: all four req_valid held with x=i+1, s=1 -> resp_id order 0,1,2,3,0, resp_y=3,6,9,12,3; req_ready is never multi-hot.
- Backpressure: resp_ready=0 for 10 cycles on a job x=3 s=0 -> resp_valid, resp_y=15 and resp_id held stable, req_ready all 0, mul_x=3 constant; next job is accepted only after resp_ready=1.
- Reset mid-job: assert rst during SETTLE (SETTLE_CYC=4) -> resp_valid never rises, busy=0 immediately; after release, req2 x=3 s=1 is granted first only if requesters 0 and 1 are idle, and returns resp_y=9.
- Stats (MULT_ARB_STATS_EN): 3 jobs from req0 and 1 job from req3 -> stat_cnt[15:0]=3, stat_cnt[63:48]=1; stat_clr together with a req0 completion -> stat_cnt[15:0]=0.
